uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk cycles per UART bit (27 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 rd_pop  input  1  one-cycle pulse; consumes FIFO head.
REQ-007 clr_err  input  1  one-cycle pulse; clears sticky error flags.
REQ-008 rx_data  output  8  FIFO head byte.
REQ-009 rx_valid  output  1  FIFO non-empty.
REQ-010 overrun  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-011 frame_err  output  1  sticky; a stop bit was sampled low.

Function
REQ-012 rx shall pass through a 2-flop synchronizer (rxs); both flops load 1 on reset.
REQ-013 FSM states: IDLE, START, DATA, STOP, RECOVER; one bit counter cnt (16 bit) and one bit index (3 bit).
REQ-014 IDLE: rxs==0 -> START, cnt<=0; otherwise remain in IDLE.
REQ-015 START: cnt increments each cycle; at cnt==CLKS_PER_BIT/2-1 (integer division), rxs==0 -> DATA, cnt<=0, index<=0; rxs==1 -> IDLE (glitch rejected, nothing pushed, no flag).
REQ-016 DATA: at cnt==CLKS_PER_BIT-1, shift rxs into bit[index], cnt<=0; after index 7 -> STOP; else index+1.
REQ-017 STOP: at cnt==CLKS_PER_BIT-1, rxs==1 -> push byte, -> IDLE; rxs==0 -> discard byte, set frame_err, -> RECOVER.
REQ-018 RECOVER: remain until rxs==1, then -> IDLE; a continuously low line (break) yields exactly one frame_err event.
REQ-019 A pushed byte shall appear on rx_data with rx_valid=1 in the cycle after the push edge.
REQ-020 rd_pop with rx_valid=1 shall advance the head on the same edge; rd_pop with rx_valid=0 shall be ignored.
REQ-021 Push into a full FIFO without a same-cycle pop shall drop the new byte, set overrun, and leave contents unchanged.
REQ-022 Push and pop in the same cycle on a full FIFO shall both succeed; overrun stays unchanged.
REQ-023 Push and pop in the same cycle on an empty FIFO: the pop is ignored and the push is stored.
REQ-024 FIFO pointers shall wrap modulo FIFO_DEPTH; the occupancy count (width log2(FIFO_DEPTH)+1) distinguishes full from empty.
REQ-025 rx_data shall read 8'h00 whenever rx_valid=0.
REQ-026 clr_err shall clear overrun and frame_err; an error event in the same cycle wins (flag = 1).
REQ-027 The receiver shall never stall on FIFO state; reception continues while full.

Reset
REQ-028 With resetn=0 on a clock edge: state IDLE, cnt=0, index=0, FIFO empty, rx_valid=0, rx_data=8'h00, overrun=0, frame_err=0.
REQ-029 Reset mid-frame shall abandon the frame with no push and no flag; after release, the FSM waits in IDLE for the next falling edge of rxs.
REQ-030 Outputs shall be defined from the first clock edge with resetn=0; no initial-value dependence.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-031 Send 0x55 as a clean 8N1 frame -> 2 + 4 + 64 + 8 cycles after the start edge (±1) rx_valid=1, rx_data=0x55; rd_pop -> rx_valid=0 next cycle.
REQ-032 3-cycle low glitch on idle rx -> no push, no flag, FSM back in IDLE.
REQ-033 Send 0xA3 with stop bit low, then rx held low for 40 cycles, then high -> frame_err=1 once, rx_valid=0; next good 0x41 is received normally.
REQ-034 Send 5 bytes 0x01..0x05 with no pops -> four entries 0x01..0x04 popped in order, overrun=1; clr_err -> overrun=0.
REQ-035 FIFO full, rd_pop asserted on the push edge of byte 0x99 -> overrun stays 0; entries read out 0x02, 0x03, 0x04, 0x99.
REQ-036 resetn=0 for 1 cycle during DATA of a frame -> no push, flags 0; the following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver (LSB first, idle high) feeding a small receive FIFO,
// with sticky overrun and framing-error flags.
//
// Ports
//   clk        in   system clock, rising edge
//   resetn     in   synchronous active-low reset
//   rx         in   asynchronous serial line
//   rd_pop     in   one-cycle pulse, consumes the FIFO head (ignored when empty)
//   clr_err    in   one-cycle pulse, clears overrun and frame_err
//   rx_data    out  FIFO head byte, 8'h00 while empty
//   rx_valid   out  FIFO non-empty
//   overrun    out  sticky, a received byte was dropped because the FIFO was full
//   frame_err  out  sticky, a stop bit was sampled low
//
// Receiver states
//   state   | meaning
//   IDLE    | line idle, waiting for rxs to go low
//   START   | half-bit wait, re-check start bit to reject glitches
//   DATA    | sample 8 data bits at mid-bit, LSB first
//   STOP    | sample stop bit; push byte or flag framing error
//   RECOVER | wait for the line to return high after a framing error
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    input  logic       rd_pop,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; loads idle level on reset so no false start.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        push;
    logic        ferr_evt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_evt = 1'b1;
                        state_d  = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RECOVER: begin
                // Only one error per break: wait for the line to go high
                // before looking for another start bit.
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic          ovf_evt;
    logic          overrun_q, frame_err_q;

    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = rd_pop && (count_q != '0);
    // A pop on the same edge frees the slot the push needs.
    assign push_ok = push && (!full || pop_ok);
    assign ovf_evt = push && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_q + CW'(push_ok) - CW'(pop_ok);
            overrun_q   <= (overrun_q & ~clr_err) | ovf_evt;
            frame_err_q <= (frame_err_q & ~clr_err) | ferr_evt;
        end
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Frames are driven bit-by-bit on rx; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB = 8;

    logic       clk;
    logic       resetn;
    logic       rx;
    logic       rd_pop;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .rd_pop   (rd_pop),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of each rx_valid rising edge.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one full 80-cycle frame; optionally pulses rd_pop so that it
    // lands on the edge where the receiver pushes. Line is left at the
    // stop-bit level.
    task automatic send(input logic [7:0] b, input logic stop, input logic pop_at_push);
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c < CPB)          rx = 1'b0;
            else if (c < 9 * CPB) rx = b[(c - CPB) / CPB];
            else                  rx = stop;
            rd_pop = pop_at_push && (c == 10 * CPB - 2);
            if (c == 0) start_cyc = cyc;
            @(posedge clk);
            #1;
        end
        rd_pop = 1'b0;
        rx = stop;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, exp);
        @(posedge clk);
        #1 rd_pop = 1'b1;
        @(posedge clk);
        #1 rd_pop = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rx      = 1'b1;
        rd_pop  = 1'b0;
        clr_err = 1'b0;
        resetn  = 1'b0;

        // Reset state after the first edge with reset low
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        idle(2);
        resetn = 1'b1;
        idle(4);

        // Clean 0x55, latency 78 +/- 1 after start edge
        rise_cyc = -1000;
        send(8'h55, 1'b1, 1'b0);
        chk("lat55_in_range", int'((rise_cyc - start_cyc) >= 77 && (rise_cyc - start_cyc) <= 79), 1);
        pop_chk("b55", 8'h55);
        @(negedge clk);
        chk("b55_after_pop_valid", rx_valid, 0);
        chk("b55_after_pop_data", rx_data, 8'h00);

        // 3-cycle glitch on idle line
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        @(negedge clk);
        chk("glitch_valid", rx_valid, 0);
        chk("glitch_ferr", frame_err, 0);
        chk("glitch_ovr", overrun, 0);
        idle(1);
        send(8'h3C, 1'b1, 1'b0);
        pop_chk("b3C", 8'h3C);

        // Framing error followed by a 40-cycle break
        send(8'hA3, 1'b0, 1'b0);
        @(negedge clk);
        chk("ferr_set", frame_err, 1);
        chk("ferr_valid", rx_valid, 0);
        idle(10);
        pulse_clr();
        idle(28);
        rx = 1'b1;
        idle(6);
        @(negedge clk);
        chk("break_single_event", frame_err, 0);
        chk("break_valid", rx_valid, 0);
        idle(1);
        send(8'h41, 1'b1, 1'b0);
        pop_chk("b41", 8'h41);
        @(negedge clk);
        chk("b41_ferr", frame_err, 0);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        pop_chk("ovr_e1", 8'h01);
        pop_chk("ovr_e2", 8'h02);
        pop_chk("ovr_e3", 8'h03);
        pop_chk("ovr_e4", 8'h04);
        @(negedge clk);
        chk("ovr_empty", rx_valid, 0);
        chk("ovr_still", overrun, 1);
        pulse_clr();
        @(negedge clk);
        chk("ovr_cleared", overrun, 0);

        // Pop on empty is ignored
        @(posedge clk);
        #1 rd_pop = 1'b1;
        @(posedge clk);
        #1 rd_pop = 1'b0;
        @(negedge clk);
        chk("empty_pop_valid", rx_valid, 0);
        chk("empty_pop_data", rx_data, 8'h00);

        // Full FIFO, pop on the push edge of 0x99
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
        send(8'h99, 1'b1, 1'b1);
        @(negedge clk);
        chk("fullpp_ovr", overrun, 0);
        pop_chk("fullpp_e1", 8'h02);
        pop_chk("fullpp_e2", 8'h03);
        pop_chk("fullpp_e3", 8'h04);
        pop_chk("fullpp_e4", 8'h99);
        @(negedge clk);
        chk("fullpp_empty", rx_valid, 0);

        // Empty FIFO, pop on the push edge of 0x5A: push stored
        send(8'h5A, 1'b1, 1'b1);
        pop_chk("emptypp", 8'h5A);
        @(negedge clk);
        chk("emptypp_after", rx_valid, 0);

        // Reset during DATA, with an old byte in the FIFO
        send(8'h11, 1'b1, 1'b0);
        rx = 1'b0;
        idle(30);
        resetn = 1'b0;
        rx = 1'b1;
        idle(1);
        resetn = 1'b1;
        idle(100);
        @(negedge clk);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 8'h00);
        chk("midrst_ovr", overrun, 0);
        chk("midrst_ferr", frame_err, 0);
        idle(1);
        send(8'h7E, 1'b1, 1'b0);
        pop_chk("b7E", 8'h7E);
        @(negedge clk);
        chk("b7E_after", rx_valid, 0);
        chk("b7E_ferr", frame_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
